// File: rtl/register_file.sv
// register_file: 32x32 operand store with one synchronous write port and two gated combinational read ports
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_write_addr,
    input  logic              i_write_en,
    input  logic [ADDR_W-1:0] i_read_a,
    input  logic              i_read_a_en,
    output logic [DATA_W-1:0] o_data_a,
    input  logic [ADDR_W-1:0] i_read_b,
    input  logic              i_read_b_en,
    output logic [DATA_W-1:0] o_data_b
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];

    // write port; reset clears every entry at once and overrides a pending write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (i_write_en) begin
            r_regs[i_write_addr] <= i_data;
        end
    end

    // read ports see stored contents only, so a same-cycle write shows up after the edge
    always_comb begin
        o_data_a = i_read_a_en ? r_regs[i_read_a] : '0;
        o_data_b = i_read_b_en ? r_regs[i_read_b] : '0;
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and random checks of register_file against an array model
module tb_register_file;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data = '0;
    logic [4:0]  waddr = '0;
    logic        we = 1'b0;
    logic [4:0]  ra = '0;
    logic        ra_en = 1'b0;
    logic [31:0] da;
    logic [4:0]  rb = '0;
    logic        rb_en = 1'b0;
    logic [31:0] db;

    logic [31:0] model [32];
    int checks = 0;
    int errors = 0;

    register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_write_addr(waddr),
        .i_write_en(we), .i_read_a(ra), .i_read_a_en(ra_en), .o_data_a(da),
        .i_read_b(rb), .i_read_b_en(rb_en), .o_data_b(db)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // one clock: edge, then model update if the write was enabled and reset was high
    task automatic tick();
        @(posedge clk);
        if (we && rst_n) model[waddr] = data;
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; data = d;
        tick();
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic check_ports(input string tag);
        #1;
        check({tag, "_A"}, da, ra_en ? model[ra] : 32'h0);
        check({tag, "_B"}, db, rb_en ? model[rb] : 32'h0);
    endtask

    initial begin
        clear_model();
        ra_en = 1'b1; rb_en = 1'b1; ra = 5'd13; rb = 5'd31;
        #12;
        check("reset_A", da, 32'h0);
        check("reset_B", db, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // asynchronous reset clears a written register without a clock edge
        write(5'd7, 32'hDEADBEEF);
        ra = 5'd7;
        #1 check("pre_reset_r7", da, 32'hDEADBEEF);
        #1 rst_n = 1'b0;
        clear_model();
        #1 check("async_reset_r7", da, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset arriving during a write wins; first edge after release accepts a write
        write(5'd7, 32'h0BADF00D);
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; data = 32'hCAFEF00D;
        #2 rst_n = 1'b0;
        clear_model();
        tick();
        check("reset_mid_write", da, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; data = 32'h00000011;
        tick();
        check("first_write_after_release", da, 32'h00000011);
        @(negedge clk);
        we = 1'b0;

        for (int i = 0; i < 32; i++) write(i[4:0], i);
        ra_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ra = i[4:0];
            #1 check("fill_A", da, i);
        end
        ra_en = 1'b0;
        #1 check("A_disabled", da, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rb = i[4:0];
            #1 check("fill_B", db, i);
        end
        rb_en = 1'b0;
        #1 check("B_disabled", db, 32'h0);
        ra_en = 1'b1; rb_en = 1'b1; ra = 5'd5; rb = 5'd5;
        #1 check("dual_same_A", da, 32'd5);
        check("dual_same_B", db, 32'd5);
        ra = 5'd3; rb = 5'd30;
        #1 check("dual_A3", da, 32'd3);
        check("dual_B30", db, 32'd30);

        // disabled write leaves the target untouched
        @(negedge clk);
        we = 1'b0; waddr = 5'd4; data = 32'hFFFFFFFF; ra = 5'd4;
        repeat (4) tick();
        check("we_gating_r4", da, 32'd4);

        // read-during-write returns old data until the edge
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; data = 32'hA5A5A5A5; ra = 5'd9;
        #1 check("rdw_before", da, 32'd9);
        tick();
        check("rdw_after", da, 32'hA5A5A5A5);
        @(negedge clk);
        we = 1'b0;

        // register 0 is an ordinary register
        rb = 5'd0;
        write(5'd0, 32'h12345678);
        #1 check("r0_write", db, 32'h12345678);
        write(5'd0, 32'h0);
        #1 check("r0_clear", db, 32'h0);

        // random traffic, reads checked just before each edge
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we = 1'($urandom); waddr = 5'($urandom); data = $urandom;
            ra = 5'($urandom); rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
            ra_en = ($urandom_range(0, 4) != 0); rb_en = ($urandom_range(0, 4) != 0);
            if (n % 7 == 0) ra = waddr;
            check_ports("rand_pre");
            tick();
            check_ports("rand_post");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
